// File: rtl/simple_gmii_tx.sv
// simple_gmii_tx
//   Transmit datapath behind the simple GMII register block. Bytes written
//   through tx_data are collected in a local frame buffer. When start is
//   seen, one Ethernet frame is sent on the GMII transmit interface. The
//   frame is preamble, SFD, payload, zero pad and a CRC-32 FCS. The start
//   bit is then cleared and tx-done is raised. Everything runs on the
//   125 MHz GTX clock.
//
// Ports
//   clk          GMII transmit clock
//   reset        synchronous, active-high reset
//   tx_data      byte to append to the frame buffer
//   tx_data_stb  one-cycle strobe qualifying tx_data
//   start        level control bit requesting a transmission
//   start_clr    one-cycle pulse clearing the control bit
//   tx_done      one-cycle pulse, frame sent (or empty start acknowledged)
//   tx_ovf       one-cycle pulse, a strobed byte was dropped
//   gmii_txd     GMII transmit data
//   gmii_tx_en   GMII transmit enable
//   gmii_tx_er   GMII transmit error, always 0
module simple_gmii_tx #(
  parameter int BUF_AW  = 11,
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_data_stb,
  input  logic       start,
  output logic       start_clr,
  output logic       tx_done,
  output logic       tx_ovf,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er
);

  // One shared counter sequences every phase, so it must hold the largest
  // of the buffer size, MIN_LEN and IFG_LEN.
  localparam int CNT_W = (BUF_AW + 2 > 16) ? BUF_AW + 2 : 16;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_C   = CNT_W'(7);
  localparam logic [CNT_W-1:0] FCS_C   = CNT_W'(4);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] IFG_C   = CNT_W'(IFG_LEN);
  localparam logic [BUF_AW:0]  WR_ONE  = (BUF_AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [BUF_AW:0]   wr_cnt_q, wr_cnt_d;
  logic [7:0]        txd_q, txd_d;
  logic              tx_en_q, tx_en_d;
  logic              start_clr_q, start_clr_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              empty_start;
  logic              wr_ok;
  logic [CNT_W-1:0]  wr_ext;
  logic [BUF_AW-1:0] rd_addr;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [2**BUF_AW];

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign wr_ok  = tx_data_stb && (state_q == IDLE) && !wr_cnt_q[BUF_AW];
  assign wr_ext = CNT_W'(wr_cnt_q);

  // Frame buffer: one write port, one registered read port so it maps to
  // block RAM. The read address is the byte needed on the wire next cycle,
  // which prefetches byte 0 during PRE/SFD and keeps DATA bubble-free.
  assign rd_addr = (state_d == DATA) ? cnt_d[BUF_AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_cnt_q[BUF_AW-1:0]] <= tx_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  // State and output registers. Every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '1;
      wr_cnt_q    <= '0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      start_clr_q <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      wr_cnt_q    <= wr_cnt_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      start_clr_q <= start_clr_d;
      tx_done_q   <= tx_done_d;
      tx_ovf_q    <= tx_ovf_d;
    end
  end

  // Next-state logic. state_d/txd_d describe the byte that will be on the
  // wire in the next cycle, so state_q always names the byte currently out.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    wr_cnt_d    = wr_ok ? (wr_cnt_q + WR_ONE) : wr_cnt_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    empty_start = 1'b0;
    tx_ovf_d    = tx_data_stb && !wr_ok;

    case (state_q)
      IDLE: begin
        crc_d = '1;
        cnt_d = '0;
        // start_clr_q high means the control bit is still clearing; ignore it.
        if (start && !start_clr_q) begin
          if ((wr_cnt_q != '0) || wr_ok) begin
            state_d = PRE;
            txd_d   = 8'h55;
            tx_en_d = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            empty_start = 1'b1;
          end
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == PRE_C) begin
          state_d = SFD;
          txd_d   = 8'hD5;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SFD: begin
        state_d = DATA;
        tx_en_d = 1'b1;
        txd_d   = rd_data_q;
        crc_d   = crc_step(crc_q, rd_data_q);
        cnt_d   = CNT_ONE;
      end
      DATA, PAD: begin
        tx_en_d = 1'b1;
        if (cnt_q < wr_ext) begin
          state_d = DATA;
          txd_d   = rd_data_q;
          crc_d   = crc_step(crc_q, rd_data_q);
          cnt_d   = cnt_q + CNT_ONE;
        end else if (cnt_q < MIN_C) begin
          state_d = PAD;
          crc_d   = crc_step(crc_q, 8'h00);
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          // The FCS is the complemented CRC, shifted out a byte at a time.
          state_d = FCS;
          txd_d   = ~crc_q[7:0];
          crc_d   = {8'h00, crc_q[31:8]};
          cnt_d   = CNT_ONE;
        end
      end
      FCS: begin
        if (cnt_q == FCS_C) begin
          state_d = IFG;
          cnt_d   = CNT_ONE;
        end else begin
          tx_en_d = 1'b1;
          txd_d   = ~crc_q[7:0];
          crc_d   = {8'h00, crc_q[31:8]};
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IFG: begin
        if (cnt_q >= IFG_C) begin
          state_d  = IDLE;
          cnt_d    = '0;
          wr_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Completion pulses land in the final IFG cycle so the control bit is
    // already clear by the time IDLE looks at start again.
    tx_done_d   = empty_start || ((state_d == IFG) && (state_q != IDLE) && (cnt_d == IFG_C));
    start_clr_d = tx_done_d;
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = 1'b0;
  assign start_clr  = start_clr_q;
  assign tx_done    = tx_done_q;
  assign tx_ovf     = tx_ovf_q;

endmodule

// File: doc/simple_gmii_tx.md
Name: simple_gmii_tx

Overview:
- Transmit datapath downstream of the simple GMII register block.
- Captures bytes written through the tx_data port into a local frame buffer. On the start command it sends one Ethernet frame on the GMII transmit interface: preamble, SFD, payload, zero pad and CRC-32 FCS.
- On completion it clears the start command and raises the tx-done status bit.
- Runs entirely in the GMII transmit clock domain, so clk is the 125 MHz GTX clock.

Parameters:
- BUF_AW, 11: frame buffer address width; capacity is 2^BUF_AW bytes.
- MIN_LEN, 60: minimum payload length before FCS; shorter frames are zero-padded. A value of 0 disables padding.
- IFG_LEN, 12: idle cycles after FCS before done is signalled.

Ports:
- clk  input  1  GMII transmit clock.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte from the register block tx_data register.
- tx_data_stb  input  1  one-cycle strobe: tx_data holds a new byte to append.
- start  input  1  level; the register block control bit.
- start_clr  output  1  one-cycle pulse that clears the control bit (drives control_clr).
- tx_done  output  1  one-cycle pulse, frame sent (drives status_set[0]).
- tx_ovf  output  1  one-cycle pulse, byte dropped (drives status_set[1]).
- gmii_txd  output  8  GMII transmit data.
- gmii_tx_en  output  1  GMII transmit enable.
- gmii_tx_er  output  1  GMII transmit error; tied 0.

Behaviour:
- Reset: all outputs 0, byte count wr_cnt=0, state IDLE. Buffer contents are don't-care.
- Registered outputs: all outputs are registered; there is no combinational path from input to output.
- Buffer write:
  - Condition: tx_data_stb=1 while in IDLE and wr_cnt < 2^BUF_AW.
  - Action: mem[wr_cnt]<=tx_data and wr_cnt++.
  - A strobe when wr_cnt=2^BUF_AW, or in any non-IDLE state, drops the byte and pulses tx_ovf in the next cycle. wr_cnt is unchanged.
- Buffer memory is single-write, single-read with a registered read, so it infers as block RAM.
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE:
  - start=1 and wr_cnt>0: go to PRE.
  - start=1 and wr_cnt=0: no frame is sent. start_clr and tx_done pulse for one cycle and the FSM stays in IDLE. The start level is ignored in the following cycle.
- PRE: 7 cycles of gmii_txd=0x55, tx_en=1. The first PRE byte is on the wire in the cycle after IDLE samples start=1, so latency is 1 cycle.
- SFD: 1 cycle of 0xD5.
- DATA: wr_cnt cycles, buffer bytes in index order from 0 to wr_cnt-1. The read is prefetched during PRE/SFD so there are no bubbles.
- PAD: max(0, MIN_LEN-wr_cnt) cycles of 0x00.
- FCS:
  - 4 cycles carrying the IEEE 802.3 CRC-32 over DATA+PAD.
  - CRC definition: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, result complemented.
  - Transmitted least-significant byte first.
  - CRC is updated one byte per cycle.
- IFG:
  - IFG_LEN cycles, tx_en=0, txd=0x00.
  - start_clr and tx_done pulse high in the last IFG cycle.
  - wr_cnt is cleared at the same edge the FSM enters IDLE.
  - Because the control register clears one edge after start_clr, IDLE never re-sees the stale start.
- Wire length: tx_en is high for exactly 8 + max(wr_cnt, MIN_LEN) + 4 cycles, contiguous.
- Reset mid-frame:
  - tx_en drops at the next edge; the frame is truncated.
  - wr_cnt is cleared.
  - No tx_done and no start_clr pulse is generated.
- tx_data_stb and start in the same IDLE cycle: the byte is written, and the frame starts with the updated wr_cnt.
- start deasserted mid-frame: ignored; the frame completes.
- tx_done and tx_ovf cannot collide because they drive different status bits, and both may pulse in the same cycle.

Test Plan:
1. Reset, then idle: gmii_tx_en=0, txd=0x00, start_clr/tx_done/tx_ovf=0 for 100 cycles.
2. MIN_LEN=0, write ASCII "123456789" (9 bytes), start=1:
   - tx_en high 21 cycles.
   - Bytes on the wire: 7×0x55, 0xD5, 0x31..0x39, 0x26, 0x39, 0xF4, 0xCB.
   - Then 12 idle cycles, with tx_done and start_clr pulsing on the 12th.
3. MIN_LEN=60, write 14 bytes, start:
   - tx_en high 72 cycles.
   - 46 bytes of 0x00 pad follow the data.
   - FCS matches a reference model CRC over all 60 bytes.
4. BUF_AW=4, write 17 bytes: the first 16 are stored and tx_ovf pulses once. The frame carries exactly bytes 0..15.
5. start=1 with an empty buffer: one-cycle start_clr and tx_done pulses, gmii_tx_en stays 0. A strobe during DATA: byte dropped, tx_ovf pulses, frame unaffected.
6. Assert reset during DATA byte 5:
   - tx_en=0 next cycle and no tx_done.
   - A following 64-byte frame is transmitted correctly from byte 0.
